// File: rtl/jtag_loader_pkg.sv
// Shared types and default sizes for the JTAG instruction-memory loader.
package jtag_loader_pkg;

    localparam int BYTE_WIDTH_DEF  = 8;
    localparam int WORD_BYTES_DEF  = 4;
    localparam int ADDR_WIDTH_DEF  = 13;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        WRITE,
        FLUSH,
        DONE
    } loader_state_e;

endpackage

// File: rtl/jtag_sync.sv
// Multi-flop single-bit synchroniser into the core clock, cleared by synchronous reset.
module jtag_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/jtag_loader.sv
// Core-clock side of the JTAG loader: handshakes bytes from the TCK receiver, packs them
// into words and writes instruction memory. Optional running checksum: JTAG_LOADER_CHECKSUM_EN.
module jtag_loader
    import jtag_loader_pkg::*;
#(
    parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
    parameter int WORD_BYTES  = WORD_BYTES_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [BYTE_WIDTH-1:0]            jtag_data_i,
    input  logic                             jtag_word_rdy_i,
    output logic                             jtag_ack_o,
    input  logic                             jtag_sel_i,
    input  logic                             jtag_reset_i,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [BYTE_WIDTH*WORD_BYTES-1:0] mem_wdata_o,
    output logic [WORD_BYTES-1:0]            mem_be_o,
    output logic                             core_rst_o,
    output logic                             overflow_o,
    output logic [31:0]                      checksum_o
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic rdy_s, sel_s, trst_s, sel_q, sel_rise, abort;

    jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_rdy  (.clk(clk_i), .rst(rst_i), .d(jtag_word_rdy_i), .q(rdy_s));
    jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_sel  (.clk(clk_i), .rst(rst_i), .d(jtag_sel_i),      .q(sel_s));
    jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_trst (.clk(clk_i), .rst(rst_i), .d(jtag_reset_i),    .q(trst_s));

    loader_state_e state, state_nxt;

    logic [IDX_W-1:0]                       idx;
    logic [WORD_BYTES-1:0][BYTE_WIDTH-1:0] word;
    logic [WORD_BYTES-1:0]                 be;
    logic [ADDR_WIDTH-1:0]                 addr;
    logic                                  ack, we, core_rst, overflow;

    assign sel_rise = sel_s & ~sel_q;
    assign abort    = trst_s && (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (sel_rise) state_nxt = WAIT;
                WAIT: begin
                    if (rdy_s)       state_nxt = ACK;
                    else if (!sel_s) state_nxt = (idx != '0) ? FLUSH : DONE;
                end
                ACK:     if (!rdy_s) state_nxt = (idx == IDX_LAST) ? WRITE : WAIT;
                WRITE:   state_nxt = WAIT;
                FLUSH:   state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Ack and write strobe are flops so the receiver and memory see glitch-free levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q    <= 1'b0;
            idx      <= '0;
            word     <= '0;
            be       <= '0;
            addr     <= '0;
            ack      <= 1'b0;
            we       <= 1'b0;
            core_rst <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sel_q <= sel_s;
            ack   <= (state_nxt == ACK);
            we    <= ((state_nxt == WRITE) || (state_nxt == FLUSH)) && !overflow;
            if (abort) begin
                addr     <= '0;
                idx      <= '0;
                word     <= '0;
                be       <= '0;
                core_rst <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (sel_rise) begin
                        addr     <= '0;
                        idx      <= '0;
                        word     <= '0;
                        be       <= '0;
                        overflow <= 1'b0;
                        core_rst <= 1'b1;
                    end
                    WAIT: if (rdy_s) begin
                        word[idx] <= jtag_data_i;
                        be[idx]   <= 1'b1;
                    end
                    ACK: if (!rdy_s && (idx != IDX_LAST)) idx <= idx + IDX_W'(1);
                    WRITE, FLUSH: begin
                        // The last address saturates; everything after it is dropped.
                        if (addr == ADDR_MAX)  overflow <= 1'b1;
                        else if (state == WRITE) addr   <= addr + ADDR_WIDTH'(1);
                        idx  <= '0;
                        word <= '0;
                        be   <= '0;
                    end
                    DONE: core_rst <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

`ifdef JTAG_LOADER_CHECKSUM_EN
    logic [31:0] checksum;

    always_ff @(posedge clk_i) begin
        if (rst_i)                          checksum <= '0;
        else if (state == IDLE && sel_rise) checksum <= '0;
        else if (we)                        checksum <= checksum + 32'(mem_wdata_o);
    end

    assign checksum_o = checksum;
`else
    assign checksum_o = '0;
`endif

    assign jtag_ack_o  = ack;
    assign mem_we_o    = we;
    assign mem_addr_o  = addr;
    assign mem_wdata_o = word;
    assign mem_be_o    = be;
    assign core_rst_o  = core_rst;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_jtag_loader.sv
// Randomised bench for jtag_loader: a four-phase byte source, a session-level write model
// and a negedge monitor that checks every memory write and ack edge.
module tb_jtag_loader;

    localparam int BW     = 8;
    localparam int WB     = 4;
    localparam int AW     = 2;
    localparam int SS     = 2;
    localparam int WW     = BW * WB;
    localparam int NWORDS = 1 << AW;
`ifdef JTAG_LOADER_CHECKSUM_EN
    localparam logic [31:0] CSUM_T2 = 32'h0A08_0604;
`else
    localparam logic [31:0] CSUM_T2 = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] jtag_data = '0;
    logic          jtag_word_rdy = 1'b0;
    logic          jtag_sel = 1'b0;
    logic          jtag_reset = 1'b0;
    logic          jtag_ack, mem_we, core_rst, overflow;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic [WB-1:0] mem_be;
    logic [31:0]   checksum;

    always #5 clk = ~clk;

    jtag_loader #(.BYTE_WIDTH(BW), .WORD_BYTES(WB), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .clk_i(clk), .rst_i(rst),
        .jtag_data_i(jtag_data), .jtag_word_rdy_i(jtag_word_rdy), .jtag_ack_o(jtag_ack),
        .jtag_sel_i(jtag_sel), .jtag_reset_i(jtag_reset),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .core_rst_o(core_rst), .overflow_o(overflow), .checksum_o(checksum)
    );

    // expected writes are pushed by the driver; observed writes are logged by the monitor
    logic [AW-1:0] exp_addr[$];
    logic [WW-1:0] exp_data[$];
    logic [WB-1:0] exp_be[$];
    logic [AW-1:0] act_addr[$];
    logic [WW-1:0] act_data[$];
    logic [WB-1:0] act_be[$];
    int rd_idx = 0, ack_cnt = 0, tests = 0, fails = 0;

    string       chk_name = "";
    logic [63:0] chk_act = '0, chk_exp = '0;
    int          chk_seq = 0, chk_done = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic ack_prev, rdy_prev;
        ack_prev = 1'b0;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we) begin
                    if (rd_idx < exp_addr.size()) begin
                        cmp("wr_addr", 64'(mem_addr), 64'(exp_addr[rd_idx]));
                        cmp("wr_data", 64'(mem_wdata), 64'(exp_data[rd_idx]));
                        cmp("wr_be", 64'(mem_be), 64'(exp_be[rd_idx]));
                        rd_idx++;
                    end else begin
                        cmp("unexpected_write", 64'(mem_we), 64'(0));
                    end
                    act_addr.push_back(mem_addr);
                    act_data.push_back(mem_wdata);
                    act_be.push_back(mem_be);
                end
                if (jtag_ack && !ack_prev) begin
                    ack_cnt++;
                    cmp("ack_rise_needs_rdy", 64'(rdy_prev), 64'(1));
                end
                if (!jtag_ack && ack_prev) cmp("ack_fall_needs_rdy_low", 64'(rdy_prev), 64'(0));
            end
            ack_prev = jtag_ack;
            rdy_prev = jtag_word_rdy;
            if (chk_seq != chk_done) begin
                cmp(chk_name, chk_act, chk_exp);
                chk_done = chk_seq;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_name = name;
        chk_act  = act;
        chk_exp  = exp;
        chk_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] act_d(input int i);
        if (i < act_data.size()) return act_data[i];
        return '1;
    endfunction

    function automatic logic [WB-1:0] act_b(input int i);
        if (i < act_be.size()) return act_be[i];
        return '0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ack"}, 64'(jtag_ack), 64'(0));
        check({tag, "_we"}, 64'(mem_we), 64'(0));
        check({tag, "_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_be"}, 64'(mem_be), 64'(0));
        check({tag, "_core_rst"}, 64'(core_rst), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_checksum"}, 64'(checksum), 64'(0));
    endtask

    // one four-phase transfer with random hold and gap times
    task automatic send_byte(input logic [BW-1:0] b);
        int n;
        jtag_data     = b;
        jtag_word_rdy = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!jtag_ack && n < 40);
        check("ack_latency", 64'(n), 64'(SS + 1));
        repeat ($urandom_range(0, 3)) tick();
        jtag_word_rdy = 1'b0;
        n = 0;
        do begin tick(); n++; end while (jtag_ack && n < 40);
        check("ack_release", 64'(jtag_ack), 64'(0));
        jtag_data = BW'($urandom);
        repeat ($urandom_range(0, 4)) tick();
    endtask

    logic [BW-1:0] sess[$];
    int            log_base = 0, ack_base = 0;

    task automatic run_session(input bit abort);
        int            nb, nw;
        logic [WW-1:0] d;
        logic [WB-1:0] b;
        logic          m_ovf;
        logic [31:0]   m_csum;
        nb     = sess.size();
        nw     = nb / WB + ((!abort && (nb % WB) != 0) ? 1 : 0);
        m_ovf  = 1'b0;
        m_csum = '0;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            b = '0;
            for (int k = 0; k < WB; k++)
                if (w * WB + k < nb) begin
                    d[k*BW +: BW] = sess[w*WB + k];
                    b[k] = 1'b1;
                end
            if (w < NWORDS) begin
                exp_addr.push_back(AW'(w));
                exp_data.push_back(d);
                exp_be.push_back(b);
                m_csum += 32'(d);
            end
            if (w >= NWORDS - 1) m_ovf = 1'b1;
        end
`ifndef JTAG_LOADER_CHECKSUM_EN
        m_csum = '0;
`endif
        ack_base = ack_cnt;
        log_base = act_addr.size();
        jtag_sel = 1'b1;
        repeat (4) tick();
        check("core_rst_session", 64'(core_rst), 64'(1));
        foreach (sess[i]) send_byte(sess[i]);
        repeat (3) tick();
        check("core_rst_session", 64'(core_rst), 64'(1));
        if (abort) begin
            jtag_reset = 1'b1;
            repeat (SS + 3) tick();
            check("abort_ack", 64'(jtag_ack), 64'(0));
            check("abort_core_rst", 64'(core_rst), 64'(0));
            jtag_reset = 1'b0;
        end
        jtag_sel = 1'b0;
        repeat (SS + 6) tick();
        check("core_rst_released", 64'(core_rst), 64'(0));
        check("writes_consumed", 64'(rd_idx), 64'(exp_addr.size()));
        check("ack_count", 64'(ack_cnt - ack_base), 64'(nb));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("checksum", 64'(checksum), 64'(m_csum));
        check("we_idle", 64'(mem_we), 64'(0));
    endtask

    initial begin : driver
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        sess = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_session(1'b0);
        check("t1_nwr", 64'(act_addr.size() - log_base), 64'(1));
        check("t1_data", 64'(act_d(log_base)), 64'h4433_2211);
        check("t1_be", 64'(act_b(log_base)), 64'hF);

        sess.delete();
        for (int i = 0; i < 8; i++) sess.push_back(BW'(i));
        run_session(1'b0);
        check("t2_nwr", 64'(act_addr.size() - log_base), 64'(2));
        check("t2_w0", 64'(act_d(log_base)), 64'h0302_0100);
        check("t2_w1", 64'(act_d(log_base + 1)), 64'h0706_0504);
        check("t2_checksum", 64'(checksum), 64'(CSUM_T2));

        sess = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_session(1'b0);
        check("t3_w0", 64'(act_d(log_base)), 64'hDDCC_BBAA);
        check("t3_w1", 64'(act_d(log_base + 1)), 64'h0000_00EE);
        check("t3_be1", 64'(act_b(log_base + 1)), 64'h1);

        sess.delete();
        for (int i = 0; i < 20; i++) sess.push_back(BW'($urandom));
        run_session(1'b0);
        check("t4_nwr", 64'(act_addr.size() - log_base), 64'(4));
        check("t4_overflow", 64'(overflow), 64'(1));
        check("t4_acks", 64'(ack_cnt - ack_base), 64'(20));

        sess = '{8'h5A, 8'hC3};
        run_session(1'b1);
        check("t5_nwr", 64'(act_addr.size() - log_base), 64'(0));

        sess = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_session(1'b0);
        check("t6_checksum", 64'(checksum), 64'(0));

        // rst_i in the middle of a word discards it and clears everything
        jtag_sel = 1'b1;
        repeat (4) tick();
        send_byte(8'h5A);
        send_byte(8'hA5);
        rst      = 1'b1;
        jtag_sel = 1'b0;
        tick();
        tick();
        check_reset("midrst");
        rst = 1'b0;
        repeat (4) tick();

        for (int s = 0; s < 12; s++) begin
            int n;
            sess.delete();
            n = $urandom_range(0, 22);
            for (int i = 0; i < n; i++) sess.push_back(BW'($urandom));
            run_session($urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
